// File: rtl/id_decode_stage_if.sv
// Fetch -> decode -> execute bus for the decode stage: handshake, captured PC
// and the decoded control word handed to execute.
interface id_decode_stage_if;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allowin;
    logic        flush;
    logic        es_allowin;
    logic        ds_valid;
    logic [31:0] ds_pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [11:0] alu_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_8;
    logic [31:0] imm;
    logic        gr_we;
    logic [4:0]  dest;
    logic        mem_we;
    logic        res_from_mem;
    logic        br_beq;
    logic        br_bne;
    logic        br_jal;
    logic        br_jr;
    logic [31:0] br_target;
    logic        rsv;

    // Environment side: fetch, execute and the flush source.
    modport master (
        output fs_valid, fs_pc, fs_inst, flush, es_allowin,
        input  ds_allowin, ds_valid, ds_pc, rs, rt, alu_op, src1_is_sa, src1_is_pc,
               src2_is_imm, src2_is_8, imm, gr_we, dest, mem_we, res_from_mem,
               br_beq, br_bne, br_jal, br_jr, br_target, rsv
    );

    modport slave (
        input  fs_valid, fs_pc, fs_inst, flush, es_allowin,
        output ds_allowin, ds_valid, ds_pc, rs, rt, alu_op, src1_is_sa, src1_is_pc,
               src2_is_imm, src2_is_8, imm, gr_we, dest, mem_we, res_from_mem,
               br_beq, br_bne, br_jal, br_jr, br_target, rsv
    );
endinterface

// File: rtl/id_decode_stage.sv
// MIPS instruction-decode stage: one-entry stage register with valid/allowin
// handshake, flush squash, and combinational decode of the held word.
module id_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic               clk,
    input  logic               reset,
    id_decode_stage_if.slave   bus
);

    // Indices into the opcode / func one-hot hit vectors.
    localparam int O_ADDIU = 0, O_LUI = 1, O_LW = 2, O_SW = 3;
    localparam int O_BEQ   = 4, O_BNE = 5, O_JAL = 6, O_SPECIAL = 7;
    localparam int F_ADDU = 0, F_SUBU = 1, F_SLT = 2, F_SLTU = 3, F_AND = 4, F_NOR = 5;
    localparam int F_OR   = 6, F_XOR  = 7, F_SLL = 8, F_SRL  = 9, F_SRA = 10, F_JR = 11;

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_pc_q, ds_pc_d;
    logic [31:0] ds_inst_q, ds_inst_d;
    logic        allowin;

    always_comb begin
        allowin    = !ds_valid_q || bus.es_allowin;
        ds_valid_d = ds_valid_q;
        ds_pc_d    = ds_pc_q;
        ds_inst_d  = ds_inst_q;
        if (bus.fs_valid && allowin && !bus.flush) begin
            ds_valid_d = 1'b1;
            ds_pc_d    = bus.fs_pc;
            ds_inst_d  = bus.fs_inst;
        end else if (bus.es_allowin || bus.flush) begin
            // pc/inst are left as-is; only the valid bit is squashed
            ds_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q <= 1'b0;
            ds_pc_q    <= RESET_PC;
            ds_inst_q  <= '0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_pc_q    <= ds_pc_d;
            ds_inst_q  <= ds_inst_d;
        end
    end

    logic [5:0]  op, func;
    logic [4:0]  rd;
    logic [7:0]  op_hit;
    logic [11:0] func_hit;

    assign op   = ds_inst_q[31:26];
    assign func = ds_inst_q[5:0];
    assign rd   = ds_inst_q[15:11];

    always_comb begin
        op_hit            = '0;
        op_hit[O_ADDIU]   = (op == 6'b001001);
        op_hit[O_LUI]     = (op == 6'b001111);
        op_hit[O_LW]      = (op == 6'b100011);
        op_hit[O_SW]      = (op == 6'b101011);
        op_hit[O_BEQ]     = (op == 6'b000100);
        op_hit[O_BNE]     = (op == 6'b000101);
        op_hit[O_JAL]     = (op == 6'b000011);
        op_hit[O_SPECIAL] = (op == 6'b000000);
    end

    // Func decode is only meaningful under the SPECIAL opcode.
    always_comb begin
        func_hit         = '0;
        func_hit[F_ADDU] = (func == 6'b100001);
        func_hit[F_SUBU] = (func == 6'b100011);
        func_hit[F_SLT]  = (func == 6'b101010);
        func_hit[F_SLTU] = (func == 6'b101011);
        func_hit[F_AND]  = (func == 6'b100100);
        func_hit[F_NOR]  = (func == 6'b100111);
        func_hit[F_OR]   = (func == 6'b100101);
        func_hit[F_XOR]  = (func == 6'b100110);
        func_hit[F_SLL]  = (func == 6'b000000);
        func_hit[F_SRL]  = (func == 6'b000010);
        func_hit[F_SRA]  = (func == 6'b000011);
        func_hit[F_JR]   = (func == 6'b001000);
        if (!op_hit[O_SPECIAL])
            func_hit = '0;
    end

    logic        r_alu, i_wr;
    logic [31:0] imm_sx, pc_plus4;

    assign r_alu    = |func_hit[F_SRA:F_ADDU];
    assign i_wr     = op_hit[O_ADDIU] | op_hit[O_LUI] | op_hit[O_LW];
    assign imm_sx   = {{16{ds_inst_q[15]}}, ds_inst_q[15:0]};
    assign pc_plus4 = ds_pc_q + 32'd4;

    always_comb begin
        bus.alu_op      = '0;
        bus.alu_op[0]   = func_hit[F_ADDU] | op_hit[O_ADDIU] | op_hit[O_LW]
                        | op_hit[O_SW] | op_hit[O_JAL];
        bus.alu_op[1]   = func_hit[F_SUBU];
        bus.alu_op[2]   = func_hit[F_SLT];
        bus.alu_op[3]   = func_hit[F_SLTU];
        bus.alu_op[4]   = func_hit[F_AND];
        bus.alu_op[5]   = func_hit[F_NOR];
        bus.alu_op[6]   = func_hit[F_OR];
        bus.alu_op[7]   = func_hit[F_XOR];
        bus.alu_op[8]   = func_hit[F_SLL];
        bus.alu_op[9]   = func_hit[F_SRL];
        bus.alu_op[10]  = func_hit[F_SRA];
        bus.alu_op[11]  = op_hit[O_LUI];

        bus.src1_is_sa  = func_hit[F_SLL] | func_hit[F_SRL] | func_hit[F_SRA];
        bus.src1_is_pc  = op_hit[O_JAL];
        bus.src2_is_imm = op_hit[O_ADDIU] | op_hit[O_LUI] | op_hit[O_LW] | op_hit[O_SW];
        bus.src2_is_8   = op_hit[O_JAL];

        bus.gr_we = r_alu | i_wr | op_hit[O_JAL];
        bus.dest  = '0;
        if (r_alu)
            bus.dest = rd;
        else if (i_wr)
            bus.dest = ds_inst_q[20:16];
        else if (op_hit[O_JAL])
            bus.dest = 5'd31;

        bus.mem_we       = op_hit[O_SW];
        bus.res_from_mem = op_hit[O_LW];
        bus.br_beq       = op_hit[O_BEQ];
        bus.br_bne       = op_hit[O_BNE];
        bus.br_jal       = op_hit[O_JAL];
        bus.br_jr        = func_hit[F_JR];

        bus.br_target = '0;
        if (op_hit[O_BEQ] || op_hit[O_BNE])
            bus.br_target = pc_plus4 + {imm_sx[29:0], 2'b00};
        else if (op_hit[O_JAL])
            bus.br_target = {pc_plus4[31:28], ds_inst_q[25:0], 2'b00};

        bus.rsv = !((|op_hit[O_JAL:O_ADDIU]) || (|func_hit));
    end

    assign bus.ds_allowin = allowin;
    assign bus.ds_valid   = ds_valid_q;
    assign bus.ds_pc      = ds_pc_q;
    assign bus.rs         = ds_inst_q[25:21];
    assign bus.rt         = ds_inst_q[20:16];
    assign bus.imm        = imm_sx;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed plus randomized bench for id_decode_stage, checked against a
// mnemonic-level reference decoder and a stage-occupancy model.
module tb_id_decode_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [11:0] alu_op;
        logic        s1sa, s1pc, s2imm, s28, gr_we;
        logic [4:0]  dest;
        logic        mem_we, rfm, beq, bne, jal, jr;
        logic [31:0] tgt;
        logic        rsv;
    } dec_t;

    localparam logic [5:0] FUNCS [12] = '{6'h21, 6'h23, 6'h2a, 6'h2b, 6'h24, 6'h25,
                                          6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h08};
    localparam logic [5:0] OPS [7]    = '{6'h09, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h03};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_decode_stage_if dif();
    id_decode_stage #(.RESET_PC(RST_PC)) dut (.clk(clk), .reset(reset), .bus(dif));

    int checks = 0;
    int errors = 0;

    logic        m_valid;
    logic [31:0] m_pc, m_inst;

    function automatic dec_t ref_decode(logic [31:0] w, logic [31:0] pc);
        dec_t  d;
        string m;
        logic [31:0] se;
        d  = '0;
        m  = "RSV";
        se = {{16{w[15]}}, w[15:0]};
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h21: m = "ADDU";  6'h23: m = "SUBU"; 6'h2a: m = "SLT";
                6'h2b: m = "SLTU";  6'h24: m = "AND";  6'h25: m = "OR";
                6'h26: m = "XOR";   6'h27: m = "NOR";  6'h00: m = "SLL";
                6'h02: m = "SRL";   6'h03: m = "SRA";  6'h08: m = "JR";
                default: m = "RSV";
            endcase
            6'h09: m = "ADDIU"; 6'h0f: m = "LUI"; 6'h23: m = "LW"; 6'h2b: m = "SW";
            6'h04: m = "BEQ";   6'h05: m = "BNE"; 6'h03: m = "JAL";
            default: m = "RSV";
        endcase
        case (m)
            "ADDU", "SUBU", "SLT", "SLTU", "AND", "NOR", "OR", "XOR", "SLL", "SRL", "SRA": begin
                case (m)
                    "ADDU": d.alu_op[0] = 1'b1;  "SUBU": d.alu_op[1] = 1'b1;
                    "SLT":  d.alu_op[2] = 1'b1;  "SLTU": d.alu_op[3] = 1'b1;
                    "AND":  d.alu_op[4] = 1'b1;  "NOR":  d.alu_op[5] = 1'b1;
                    "OR":   d.alu_op[6] = 1'b1;  "XOR":  d.alu_op[7] = 1'b1;
                    "SLL":  d.alu_op[8] = 1'b1;  "SRL":  d.alu_op[9] = 1'b1;
                    default: d.alu_op[10] = 1'b1;
                endcase
                d.s1sa  = (m == "SLL" || m == "SRL" || m == "SRA");
                d.gr_we = 1'b1;
                d.dest  = w[15:11];
            end
            "JR":    d.jr = 1'b1;
            "ADDIU": begin d.alu_op[0] = 1'b1; d.s2imm = 1'b1; d.gr_we = 1'b1; d.dest = w[20:16]; end
            "LUI":   begin d.alu_op[11] = 1'b1; d.s2imm = 1'b1; d.gr_we = 1'b1; d.dest = w[20:16]; end
            "LW":    begin d.alu_op[0] = 1'b1; d.s2imm = 1'b1; d.gr_we = 1'b1; d.dest = w[20:16]; d.rfm = 1'b1; end
            "SW":    begin d.alu_op[0] = 1'b1; d.s2imm = 1'b1; d.mem_we = 1'b1; end
            "BEQ", "BNE": begin
                d.beq = (m == "BEQ");
                d.bne = (m == "BNE");
                d.tgt = pc + 32'd4 + se * 32'd4;
            end
            "JAL": begin
                d.alu_op[0] = 1'b1; d.s1pc = 1'b1; d.s28 = 1'b1; d.jal = 1'b1;
                d.gr_we = 1'b1; d.dest = 5'd31;
                d.tgt = ((pc + 32'd4) & 32'hF000_0000) + (32'(w[25:0]) * 32'd4);
            end
            default: d.rsv = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rand_inst();
        int k;
        logic [31:0] r;
        k = $urandom_range(0, 19);
        r = $urandom;
        if (k < 12) return {6'b0, r[25:6], FUNCS[k]};
        if (k < 19) return {OPS[k-12], r[25:0]};
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic dec_t dut_dec();
        dec_t a;
        a = {dif.alu_op, dif.src1_is_sa, dif.src1_is_pc, dif.src2_is_imm, dif.src2_is_8,
             dif.gr_we, dif.dest, dif.mem_we, dif.res_from_mem, dif.br_beq, dif.br_bne,
             dif.br_jal, dif.br_jr, dif.br_target, dif.rsv};
        return a;
    endfunction

    task automatic check_all(string tag);
        chk({tag, ".valid"},   64'(dif.ds_valid),   64'(m_valid));
        chk({tag, ".allowin"}, 64'(dif.ds_allowin), 64'(!m_valid || dif.es_allowin));
        chk({tag, ".pc"},      64'(dif.ds_pc),      64'(m_pc));
        chk({tag, ".rs"},      64'(dif.rs),         64'(m_inst[25:21]));
        chk({tag, ".rt"},      64'(dif.rt),         64'(m_inst[20:16]));
        chk({tag, ".imm"},     64'(dif.imm),        64'({{16{m_inst[15]}}, m_inst[15:0]}));
        chk({tag, ".dec"},     64'(dut_dec()),      64'(ref_decode(m_inst, m_pc)));
    endtask

    task automatic drive(logic v, logic [31:0] pc, logic [31:0] inst, logic es, logic fl);
        dif.fs_valid   = v;
        dif.fs_pc      = pc;
        dif.fs_inst    = inst;
        dif.es_allowin = es;
        dif.flush      = fl;
    endtask

    // Advance one clock, updating the occupancy model from the inputs seen at the edge.
    task automatic tick(string tag);
        logic        nv;
        logic [31:0] np, ni;
        nv = m_valid; np = m_pc; ni = m_inst;
        if (reset) begin
            nv = 1'b0; np = RST_PC; ni = '0;
        end else if (dif.fs_valid && (!m_valid || dif.es_allowin) && !dif.flush) begin
            nv = 1'b1; np = dif.fs_pc; ni = dif.fs_inst;
        end else if (dif.es_allowin || dif.flush) begin
            nv = 1'b0;
        end
        @(posedge clk);
        #1;
        m_valid = nv; m_pc = np; m_inst = ni;
        check_all(tag);
    endtask

    initial begin
        dec_t rsv_only;
        m_valid = 1'b0; m_pc = RST_PC; m_inst = '0;
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        tick("rst0");
        tick("rst1");
        chk("rst.valid",   64'(dif.ds_valid),   64'(0));
        chk("rst.allowin", 64'(dif.ds_allowin), 64'(1));
        chk("rst.pc",      64'(dif.ds_pc),      64'(32'hBFC0_0000));
        chk("rst.alu_op",  64'(dif.alu_op),     64'(12'h100));
        chk("rst.sa",      64'(dif.src1_is_sa), 64'(1));
        chk("rst.gr_we",   64'(dif.gr_we),      64'(1));
        chk("rst.dest",    64'(dif.dest),       64'(0));
        reset = 1'b0;

        drive(1'b1, 32'hBFC0_0000, 32'h0022_1821, 1'b1, 1'b0);
        tick("addu");
        chk("addu.valid",  64'(dif.ds_valid), 64'(1));
        chk("addu.alu_op", 64'(dif.alu_op),   64'(12'h001));
        chk("addu.rs",     64'(dif.rs),       64'(1));
        chk("addu.rt",     64'(dif.rt),       64'(2));
        chk("addu.dest",   64'(dif.dest),     64'(3));
        chk("addu.gr_we",  64'(dif.gr_we),    64'(1));
        chk("addu.rsv",    64'(dif.rsv),      64'(0));

        drive(1'b1, 32'hBFC0_0004, 32'h2422_FFFC, 1'b1, 1'b0);
        tick("addiu");
        chk("addiu.imm",  64'(dif.imm),  64'(32'hFFFF_FFFC));
        chk("addiu.dest", 64'(dif.dest), 64'(2));
        drive(1'b1, 32'hBFC0_0008, 32'h8FA4_0008, 1'b1, 1'b0);
        tick("lw");
        chk("lw.imm",   64'(dif.imm),          64'(8));
        chk("lw.rfm",   64'(dif.res_from_mem), 64'(1));
        chk("lw.dest",  64'(dif.dest),         64'(4));
        chk("lw.s2imm", 64'(dif.src2_is_imm),  64'(1));

        drive(1'b1, 32'hBFC0_0000, 32'h1022_0003, 1'b1, 1'b0);
        tick("beq");
        chk("beq.br",    64'(dif.br_beq),    64'(1));
        chk("beq.tgt",   64'(dif.br_target), 64'(32'hBFC0_0010));
        chk("beq.gr_we", 64'(dif.gr_we),     64'(0));
        drive(1'b1, 32'hBFC0_0004, 32'h0C00_0100, 1'b1, 1'b0);
        tick("jal");
        chk("jal.tgt",  64'(dif.br_target), 64'(32'hB000_0400));
        chk("jal.dest", 64'(dif.dest),      64'(31));
        chk("jal.s28",  64'(dif.src2_is_8), 64'(1));

        // Stall: held word must not move while fetch keeps offering the next one.
        drive(1'b1, 32'h0000_0100, 32'h0022_1821, 1'b1, 1'b0);
        tick("stall.cap");
        drive(1'b1, 32'h0000_0104, 32'h2403_0005, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick("stall.hold");
            chk("stall.allowin", 64'(dif.ds_allowin), 64'(0));
            chk("stall.pc",      64'(dif.ds_pc),      64'(32'h0000_0100));
        end
        dif.es_allowin = 1'b1;
        tick("stall.release");
        chk("release.pc",    64'(dif.ds_pc),    64'(32'h0000_0104));
        chk("release.valid", 64'(dif.ds_valid), 64'(1));
        dif.fs_valid = 1'b0;
        tick("release.drain");
        chk("drain.valid", 64'(dif.ds_valid), 64'(0));

        // Reset during a stall wins over fetch and flush.
        drive(1'b1, 32'h0000_0200, 32'h0022_1821, 1'b1, 1'b0);
        tick("rststall.cap");
        drive(1'b1, 32'h0000_0204, 32'h0022_1821, 1'b0, 1'b1);
        reset = 1'b1;
        tick("rststall");
        chk("rststall.valid", 64'(dif.ds_valid), 64'(0));
        chk("rststall.pc",    64'(dif.ds_pc),    64'(32'hBFC0_0000));
        reset = 1'b0;

        // Flush with a simultaneous offer drops the instruction.
        drive(1'b1, 32'h0000_0300, 32'hFC00_0000, 1'b1, 1'b1);
        tick("flush");
        chk("flush.valid", 64'(dif.ds_valid), 64'(0));
        dif.flush = 1'b0;
        tick("rsv");
        rsv_only = '0;
        rsv_only.rsv = 1'b1;
        chk("rsv.valid", 64'(dif.ds_valid), 64'(1));
        chk("rsv.dec",   64'(dut_dec()),    64'(rsv_only));

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, rand_inst(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 63) == 0);
            tick("rand");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
